// File: rtl/gate_truth_table_scanner_pkg.sv
// Shared encodings and golden truth tables for the gate truth-table scanner.
// Table bit i holds the gate result for operand vector {a,b} = i.
package gate_truth_table_scanner_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SETTLE = 3'd1;
  localparam logic [2:0] ENC_SAMPLE = 3'd2;
  localparam logic [2:0] ENC_CHECK  = 3'd3;
  localparam logic [2:0] ENC_DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_SETTLE = ENC_SETTLE,
    ST_SAMPLE = ENC_SAMPLE,
    ST_CHECK  = ENC_CHECK,
    ST_DONE   = ENC_DONE
  } scan_state_t;

  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_NOT = 4'b0011;

  localparam int NUM_VEC = 4;

  // Mismatch flags ordered {not, or, and}.
  function automatic logic [2:0] tt_fail_mask(input logic [3:0] and_tt,
                                              input logic [3:0] or_tt,
                                              input logic [3:0] not_tt);
    return {(not_tt != TT_NOT), (or_tt != TT_OR), (and_tt != TT_AND)};
  endfunction

endpackage

// File: rtl/gate_truth_table_scanner_if.sv
// Bundle between the scanner (slave side) and its controller plus gate unit (master side).
interface gate_truth_table_scanner_if;
  import gate_truth_table_scanner_pkg::*;

  // Handshake: start is a one-cycle request honoured only while idle; busy rises the
  // cycle after an accepted start and stays high through the single-cycle done pulse.
  // abort cancels a running scan (no done); results hold from done until start/abort/rst.
  logic        start;
  logic        abort;
  logic        a_out;
  logic        b_out;
  logic        and_in;
  logic        or_in;
  logic        not_in;
  logic [3:0]  and_tt;
  logic [3:0]  or_tt;
  logic [3:0]  not_tt;
  logic [2:0]  fail_mask;
  logic        pass;
  logic        busy;
  logic        done;
  scan_state_t dbg_state;

  modport slave (
    input  start, abort, and_in, or_in, not_in,
    output a_out, b_out, and_tt, or_tt, not_tt, fail_mask, pass, busy, done, dbg_state
  );

  modport master (
    output start, abort, and_in, or_in, not_in,
    input  a_out, b_out, and_tt, or_tt, not_tt, fail_mask, pass, busy, done, dbg_state
  );

endinterface

// File: rtl/gate_truth_table_scanner_settle_timer.sv
// Loadable down-counter that flags when the current operand vector has settled.
module gate_truth_table_scanner_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/gate_truth_table_scanner.sv
// Drives all four {a,b} vectors into a gate unit, captures AND/OR/NOT truth tables
// and compares them against the golden tables, reporting per-gate pass/fail.
module gate_truth_table_scanner
  import gate_truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic                      clk,
  input logic                      rst,
  gate_truth_table_scanner_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX = 2'(NUM_VEC - 1);

  scan_state_t r_state;
  logic [1:0]  r_idx;
  logic [1:0]  r_ab;
  logic [3:0]  r_and_tt;
  logic [3:0]  r_or_tt;
  logic [3:0]  r_not_tt;
  logic [2:0]  r_fail_mask;
  logic        r_pass;
  logic        r_busy;
  logic        r_done;

  logic        w_start_ok;
  logic        w_abort_ok;
  logic        w_timer_load;
  logic        w_settled;
  logic [2:0]  w_fail_mask;

  assign w_start_ok   = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_abort_ok   = (r_state != ST_IDLE) && bus.abort;
  // Reload the settle count whenever a vector is (re)presented to the gate unit.
  assign w_timer_load = w_start_ok || ((r_state == ST_SAMPLE) && (r_idx != LAST_IDX));
  assign w_fail_mask  = tt_fail_mask(r_and_tt, r_or_tt, r_not_tt);

  gate_truth_table_scanner_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (LOAD_VAL),
    .i_en       (r_state == ST_SETTLE),
    .o_expired  (w_settled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_ab        <= 2'd0;
      r_and_tt    <= 4'd0;
      r_or_tt     <= 4'd0;
      r_not_tt    <= 4'd0;
      r_fail_mask <= 3'd0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_abort_ok) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_ab        <= 2'd0;
      r_and_tt    <= 4'd0;
      r_or_tt     <= 4'd0;
      r_not_tt    <= 4'd0;
      r_fail_mask <= 3'd0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ab   <= 2'd0;
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (w_start_ok) begin
            r_state     <= ST_SETTLE;
            r_idx       <= 2'd0;
            r_and_tt    <= 4'd0;
            r_or_tt     <= 4'd0;
            r_not_tt    <= 4'd0;
            r_fail_mask <= 3'd0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_settled) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_and_tt[r_idx] <= bus.and_in;
          r_or_tt[r_idx]  <= bus.or_in;
          r_not_tt[r_idx] <= bus.not_in;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_CHECK;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_ab    <= r_idx + 2'd1;
            r_state <= ST_SETTLE;
          end
        end
        ST_CHECK: begin
          r_fail_mask <= w_fail_mask;
          r_pass      <= (w_fail_mask == 3'd0);
          r_done      <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ab    <= 2'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_out     = r_ab[1];
  assign bus.b_out     = r_ab[0];
  assign bus.and_tt    = r_and_tt;
  assign bus.or_tt     = r_or_tt;
  assign bus.not_tt    = r_not_tt;
  assign bus.fail_mask = r_fail_mask;
  assign bus.pass      = r_pass;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule
